// File: rtl/rv_branch_pkg.sv
// Shared definitions for the RV32I branch resolution unit.
//   - funct3 encodings of the six conditional branches
//   - br_state_t : redirect state machine encoding
//   - bht_cnt_t  : 2-bit saturating predictor counter and its four values
//   - bht_next   : saturating counter step toward taken / not-taken
package rv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_t;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t SNT = 2'b00;  // strongly not-taken
  localparam bht_cnt_t WNT = 2'b01;  // weakly not-taken (reset value)
  localparam bht_cnt_t WT  = 2'b10;  // weakly taken
  localparam bht_cnt_t ST  = 2'b11;  // strongly taken

  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// bht_2bit: array of 2-bit saturating branch counters.
//   clk, rst_n          : clock, asynchronous active-low reset (all counters -> WNT)
//   rd_idx / rd_taken   : asynchronous lookup, returns the counter MSB
//   upd_en / upd_idx /
//   upd_taken           : synchronous update, one counter stepped per clock
// A lookup of the index being updated in the same cycle sees the old value,
// since the read is taken from the registered array.
module bht_2bit
  import rv_branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_cnt_t cnt_q [ENTRIES];
  bht_cnt_t cnt_d [ENTRIES];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) cnt_d[upd_idx] = bht_next(cnt_q[upd_idx], upd_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution for RV32I.
//   ex_*            : branch from execute (valid/ready), PC, immediate, prediction
//   BrUn            : comparator select (1 = unsigned), from funct3 alone
//   BrEq, BrLt      : comparator results, same cycle
//   redirect_*      : corrected fetch PC to fetch (valid/ready)
//   flush           : one-cycle kill of IF/ID after the redirect is taken
//   if_pc /
//   if_pred_taken   : BHT lookup for fetch
//   mispredict_cnt  : saturating count of mispredicted branches
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. A source holding valid keeps its payload stable until that edge; ready
// may depend on state only, never on valid. Here ex_ready is high only in IDLE,
// and redirect_pc is frozen for as long as redirect_valid is high.
module branch_resolve
  import rv_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             BrUn,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  br_state_t        state_q, state_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic            taken;
  logic            legal;
  logic            accept;
  logic            mispredict;
  logic [XLEN-1:0] target;
  logic            unused_if_pc_bits;

  // funct3[1] separates the unsigned forms (BLTU/BGEU) from the signed ones.
  assign BrUn = ex_funct3[1];

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      F3_BEQ:          taken = BrEq;
      F3_BNE:          taken = !BrEq;
      F3_BLT, F3_BLTU: taken = BrLt;
      F3_BGE, F3_BGEU: taken = !BrLt;
      default:         legal = 1'b0;  // 010/011: resolved not-taken, BHT untouched
    endcase
  end

  assign ex_ready   = (state_q == IDLE);
  assign accept     = ex_valid && ex_ready;
  assign target     = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
  assign mispredict = accept && (taken != ex_pred_taken);

  always_comb begin
    state_d          = state_q;
    redirect_pc_d    = redirect_pc_q;
    mispredict_cnt_d = mispredict_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = target;
        end
      end
      REDIRECT: if (redirect_ready) state_d = FLUSH;
      FLUSH:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (mispredict && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == FLUSH);
  assign mispredict_cnt = mispredict_cnt_q;

  // Only the word-index bits of the fetch PC address the table.
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_taken  (if_pred_taken),
    .upd_en    (accept && legal),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int XLEN        = 32;
  localparam int BHT_ENTRIES = 16;
  localparam int CNT_W       = 4;   // small so saturation is reachable

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             ex_valid, ex_ready, ex_pred_taken;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc, ex_imm;
  logic             BrUn, BrEq, BrLt;
  logic             redirect_valid, redirect_ready, flush, if_pred_taken;
  logic [XLEN-1:0]  redirect_pc, if_pc;
  logic [CNT_W-1:0] mispredict_cnt;

  // Comparator operands; the bench plays the comparator, steered by the DUT's BrUn.
  logic [31:0] op_a, op_b;
  assign BrEq = (op_a == op_b);
  assign BrLt = BrUn ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  branch_resolve #(.XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
    .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .mispredict_cnt(mispredict_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int          bht_m [BHT_ENTRIES];
  int          mcnt_m;
  bit          m_pend, m_flush;
  logic [31:0] m_rpc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_ENTRIES);
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;
    mcnt_m = 0; m_pend = 0; m_flush = 0; m_rpc = '0;
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic model_clock();
    bit t;
    int i;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_pend) begin
      if (redirect_ready) begin m_pend = 0; m_flush = 1; end
    end else if (ex_valid) begin
      t = ref_taken(ex_funct3, op_a, op_b);
      if (ref_legal(ex_funct3)) begin
        i = idx_of(ex_pc);
        if (t && bht_m[i] < 3) bht_m[i]++;
        else if (!t && bht_m[i] > 0) bht_m[i]--;
      end
      if (t != ex_pred_taken) begin
        m_pend = 1;
        m_rpc  = t ? ex_pc + ex_imm : ex_pc + 32'd4;
        if (mcnt_m < (1 << CNT_W) - 1) mcnt_m++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                              input logic pred, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
    ex_pred_taken = pred; op_a = a; op_b = b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0;
    ex_pred_taken = 1'b0; op_a = '0; op_b = '0; redirect_ready = 1'b0;
    if_pc = $urandom & 32'hFFFF_FFFC;
    model_reset();
    #2;
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
    n_vec++; if (mispredict_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt); end
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_if_pred: got %b want 0", if_pred_taken); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq_predicted();
    logic [31:0] v;
    v = $urandom;
    drive_branch(3'b000, 32'h100, 32'h20, 1'b1, v, v);
    if_pc = 32'h100;
    #2;
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL beq_ex_ready: got %b want 1", ex_ready); end
    n_vec++; if (BrUn !== 1'b0) begin n_err++; $display("FAIL beq_brun: got %b want 0", BrUn); end
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL beq_bht_pre: got %b want 0", if_pred_taken); end
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_no_redirect: got %b want 0", redirect_valid); end
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL beq_bht_10: got %b want 1", if_pred_taken); end
    tick();
    #2;
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL beq_no_flush: got %b want 0", flush); end
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL beq_ready_after: got %b want 1", ex_ready); end
    tick();
  endtask

  task automatic test_bne_mispredict();
    logic [31:0] v;
    v = $urandom;
    drive_branch(3'b001, 32'h200, $urandom & 32'hFFFF_FFFE, 1'b1, v, v);
    redirect_ready = 1'b1;
    tick();                                   // accept edge N
    ex_valid = 1'b0;
    #2;                                       // cycle N+1
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL bne_rv_n1: got %b want 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h204) begin n_err++; $display("FAIL bne_rpc: got %h want 00000204", redirect_pc); end
    n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL bne_ready_n1: got %b want 0", ex_ready); end
    n_vec++; if (mispredict_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL bne_cnt: got %0d want 1", mispredict_cnt); end
    tick();
    #2;                                       // cycle N+2
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL bne_flush_n2: got %b want 1", flush); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bne_rv_n2: got %b want 0", redirect_valid); end
    n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL bne_ready_n2: got %b want 0", ex_ready); end
    tick();
    #2;                                       // cycle N+3
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL bne_flush_n3: got %b want 0", flush); end
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL bne_ready_n3: got %b want 1", ex_ready); end
    redirect_ready = 1'b0;
  endtask

  task automatic test_brun_and_wrap();
    ex_valid = 1'b0;
    ex_funct3 = 3'b110; #1;
    n_vec++; if (BrUn !== 1'b1) begin n_err++; $display("FAIL brun_bltu: got %b want 1", BrUn); end
    ex_funct3 = 3'b101; #1;
    n_vec++; if (BrUn !== 1'b0) begin n_err++; $display("FAIL brun_bge: got %b want 0", BrUn); end
    tick();
    // BGEU with a >= b unsigned but a < b signed: taken only if BrUn steers correctly.
    drive_branch(3'b111, 32'hFFFF_FFF0, 32'h20, 1'b0, 32'h8000_0005, 32'h0000_0003);
    redirect_ready = 1'b1;
    #2;
    n_vec++; if (BrUn !== 1'b1) begin n_err++; $display("FAIL brun_bgeu: got %b want 1", BrUn); end
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL wrap_rv: got %b want 1", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h0000_0010) begin n_err++; $display("FAIL wrap_rpc: got %h want 00000010", redirect_pc); end
    tick();
    tick();
    #2;
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready: got %b want 1", ex_ready); end
    redirect_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] pc, exp_pc;
    logic [CNT_W-1:0] cnt_hold;
    pc = $urandom & 32'hFFFF_FFFC;
    exp_pc = pc + 32'd4;
    drive_branch(3'b000, pc, $urandom & 32'hFFFF_FFFE, 1'b1, 32'd1, 32'd2);
    redirect_ready = 1'b0;
    tick();
    cnt_hold = CNT_W'(mcnt_m);
    for (int c = 0; c < 5; c++) begin
      // A different, mispredicting branch is offered and must be ignored.
      drive_branch(3'b001, $urandom & 32'hFFFF_FFFC, $urandom, 1'b0, 32'd7, 32'd9);
      #2;
      n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL stall_rv c%0d: got %b want 1", c, redirect_valid); end
      n_vec++; if (redirect_pc !== exp_pc) begin n_err++; $display("FAIL stall_rpc c%0d: got %h want %h", c, redirect_pc, exp_pc); end
      n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready c%0d: got %b want 0", c, ex_ready); end
      n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL stall_flush c%0d: got %b want 0", c, flush); end
      n_vec++; if (mispredict_cnt !== cnt_hold) begin n_err++; $display("FAIL stall_cnt c%0d: got %0d want %0d", c, mispredict_cnt, cnt_hold); end
      tick();
    end
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    #2;
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL stall_flush_at_ready: got %b want 0", flush); end
    tick();
    redirect_ready = 1'b0;
    #2;
    n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL stall_flush_after: got %b want 1", flush); end
    tick();
    #2;
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_end: got %b want 1", ex_ready); end
  endtask

  task automatic test_back_to_back_saturate();
    logic exp;
    if_pc = 32'h40;
    for (int c = 0; c < 6; c++) begin
      drive_branch(3'b000, 32'h40, 32'h10, 1'b1, 32'd5, 32'd5);
      #2;
      exp = (bht_m[idx_of(32'h40)] >= 2);    // pre-update value
      n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b want 1", c, ex_ready); end
      n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL b2b_rv c%0d: got %b want 0", c, redirect_valid); end
      n_vec++; if (if_pred_taken !== exp) begin n_err++; $display("FAIL b2b_lookup c%0d: got %b want %b", c, if_pred_taken, exp); end
      tick();
    end
    // One not-taken from strongly taken stays predicted-taken.
    drive_branch(3'b000, 32'h40, 32'h10, 1'b0, 32'd5, 32'd6);
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_after_nt: got %b want 1", if_pred_taken); end
    tick();
  endtask

  task automatic test_async_reset();
    drive_branch(3'b100, 32'h300, 32'h40, 1'b1, 32'd9, 32'd3);  // not taken, predicted taken
    redirect_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL ar_rv_before: got %b want 1", redirect_valid); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL ar_rv_drop: got %b want 0", redirect_valid); end
    n_vec++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL ar_rpc: got %h want 0", redirect_pc); end
    n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %b want 1", ex_ready); end
    n_vec++; if (mispredict_cnt !== '0) begin n_err++; $display("FAIL ar_cnt: got %0d want 0", mispredict_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    if_pc = 32'h40;
    tick();
    #2;
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL ar_no_flush1: got %b want 0", flush); end
    n_vec++; if (if_pred_taken !== 1'b0) begin n_err++; $display("FAIL ar_bht_reset: got %b want 0", if_pred_taken); end
    tick();
    #2;
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL ar_no_flush2: got %b want 0", flush); end
    // Index 0 -> 10 via a taken BEQ, then funct3 010 must not touch it.
    drive_branch(3'b000, 32'h80, 32'h8, 1'b1, 32'd1, 32'd1);
    tick();
    drive_branch(3'b010, 32'h80, 32'h8, 1'b0, 32'd1, 32'd1);
    if_pc = 32'h80;
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (if_pred_taken !== 1'b1) begin n_err++; $display("FAIL f3_010_bht: got %b want 1", if_pred_taken); end
    n_vec++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL f3_010_rv: got %b want 0", redirect_valid); end
    drive_branch(3'b011, 32'h80, 32'h8, 1'b1, 32'd1, 32'd1);
    tick();
    ex_valid = 1'b0;
    #2;
    n_vec++; if (redirect_pc !== 32'h84) begin n_err++; $display("FAIL f3_011_rpc: got %h want 00000084", redirect_pc); end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit exp_bht;
    for (int c = 0; c < 400; c++) begin
      a = $urandom;
      drive_branch(3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFE,
                   1'($urandom_range(0, 1)), a, ($urandom_range(0, 2) == 0) ? a : $urandom);
      ex_valid = ($urandom_range(0, 3) != 0);
      redirect_ready = ($urandom_range(0, 2) != 0);
      if_pc = $urandom & 32'hFFFF_FFFC;
      #2;
      exp_bht = (bht_m[idx_of(if_pc)] >= 2);
      n_vec++; if (ex_ready !== !(m_pend || m_flush)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, ex_ready, !(m_pend || m_flush)); end
      n_vec++; if (redirect_valid !== m_pend) begin n_err++; $display("FAIL rnd_rv c%0d: got %b want %b", c, redirect_valid, m_pend); end
      if (m_pend) begin
        n_vec++; if (redirect_pc !== m_rpc) begin n_err++; $display("FAIL rnd_rpc c%0d: got %h want %h", c, redirect_pc, m_rpc); end
      end
      n_vec++; if (flush !== m_flush) begin n_err++; $display("FAIL rnd_flush c%0d: got %b want %b", c, flush, m_flush); end
      n_vec++; if (mispredict_cnt !== CNT_W'(mcnt_m)) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, mispredict_cnt, mcnt_m); end
      n_vec++; if (if_pred_taken !== exp_bht) begin n_err++; $display("FAIL rnd_bht c%0d: got %b want %b", c, if_pred_taken, exp_bht); end
      n_vec++; if (BrUn !== ex_funct3[1]) begin n_err++; $display("FAIL rnd_brun c%0d: got %b want %b", c, BrUn, ex_funct3[1]); end
      tick();
    end
    ex_valid = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_beq_predicted();
    test_bne_mispredict();
    test_brun_and_wrap();
    test_stall();
    test_back_to_back_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit for the RV32I execute stage. It is the control side of the branch comparator: it drives the comparator's `BrUn` select from the branch `funct3` and consumes `BrEq`/`BrLt` to decide taken/not-taken. It checks the outcome against the fetch-stage prediction, issues a redirect to fetch over a valid/ready handshake and pulses a pipeline flush. It also owns a small 2-bit branch history table (BHT) that fetch queries each cycle.

## Interface
- `XLEN`, 32: data/PC width.
- `BHT_ENTRIES`, 16: number of 2-bit counters; power of two, ≥2.
- `CNT_W`, 16: width of the mispredict counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  a branch is presented in execute.
- `ex_ready`  out  1  the unit accepts the branch this cycle.
- `ex_funct3`  in  3  branch `funct3`.
- `ex_pc`  in  XLEN  PC of the branch.
- `ex_imm`  in  XLEN  sign-extended B-immediate.
- `ex_pred_taken`  in  1  prediction fetch made for this branch.
- `BrUn`  out  1  to comparator: 1 = unsigned compare.
- `BrEq`, `BrLt`  in  1 each  from comparator; combinational, same cycle.
- `redirect_valid`  out  1  corrected PC is pending.
- `redirect_ready`  in  1  fetch takes the redirect.
- `redirect_pc`  out  XLEN  corrected fetch PC.
- `flush`  out  1  one-cycle kill of the IF/ID stages.
- `if_pc`  in  XLEN  fetch PC for the BHT lookup.
- `if_pred_taken`  out  1  BHT prediction for `if_pc`.
- `mispredict_cnt`  out  CNT_W  saturating mispredict count.

## Operation
- `BrUn = ex_funct3[1]`, combinational and independent of state.
- Taken decode:
  - 000 BEQ: `BrEq`.
  - 001 BNE: `!BrEq`.
  - 100/110 BLT/BLTU: `BrLt`.
  - 101/111 BGE/BGEU: `!BrLt`.
  - 010/011: not taken, and the BHT is not updated.
- Accept occurs when `ex_valid && ex_ready`.
  - Actual target: `ex_pc + ex_imm` if taken, else `ex_pc + 4`. Both are modulo 2^XLEN; wrap-around is silent.
  - A mispredict occurs when taken differs from `ex_pred_taken`.
- State machine:
  - IDLE: `ex_ready = 1`. An accept with a mispredict latches the target into `redirect_pc` and moves to REDIRECT. A correct prediction stays in IDLE.
  - REDIRECT: `redirect_valid = 1`, `ex_ready = 0`. `redirect_pc` is held stable until `redirect_valid && redirect_ready`, then the state moves to FLUSH.
  - FLUSH: `flush = 1` for exactly one cycle, `ex_ready = 0`, then IDLE.
- BHT:
  - Index is `pc[2+log2(BHT_ENTRIES)-1 : 2]`.
  - Counters reset to 01 (weakly not-taken).
  - On accept of a legal `funct3`: increment toward 11 if taken, decrement toward 00 if not taken, saturating.
  - `if_pred_taken = counter[if_index][1]`, combinational.
  - A lookup and an update of the same index in the same cycle returns the old value.
- `mispredict_cnt` increments on each mispredicting accept and saturates at all-ones.

## Timing
- Reset values: state IDLE, `redirect_valid = 0`, `redirect_pc = 0`, `flush = 0`, `mispredict_cnt = 0`, all BHT = 01. With no branch pending, `ex_ready = 1` and `if_pred_taken = 0` during reset.
- Mispredict accepted at cycle N:
  - `redirect_valid` is high from N+1.
  - If `redirect_ready` is high at N+1, `flush` is high at N+2.
  - `ex_ready` is high again at N+3.
- Correct prediction: no redirect or flush; back-to-back accepts every cycle.
- `redirect_ready` held low: the unit stays in REDIRECT with `redirect_pc` stable, and the stall has no upper bound.
- `ex_valid` while `ex_ready = 0`: ignored. The upstream stage must hold the branch.
- Asynchronous reset asserted mid-REDIRECT or mid-FLUSH: outputs drop to reset values immediately. The pending redirect is discarded and no flush is issued.
- The BHT update and `mispredict_cnt` are written at the accept clock edge.

## Structure
- Shared package `rv_branch_pkg` holds:
  - `funct3` constants `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - State enum `br_state_t` (IDLE/REDIRECT/FLUSH).
  - A 2-bit counter typedef with constants `SNT`, `WNT`, `WT`, `ST`.
- One sub-module: `bht_2bit`, the counter array with an asynchronous read port and a synchronous update port. The state machine and decode stay in `branch_resolve`.

## Test plan
- Reset, then BEQ with `BrEq = 1`, `ex_pred_taken = 1`, `ex_pc = 0x100`, `ex_imm = 0x20`: no redirect, no flush. The counter at index 0 goes 01→10.
- BNE with `BrEq = 1`, `ex_pred_taken = 1`, `ex_pc = 0x200`: `redirect_pc = 0x204` at N+1, `flush` at N+2, `mispredict_cnt = 1`.
- BLTU: `BrUn = 1`. BGE: `BrUn = 0`. BGEU with `BrLt = 0`, `pred = 0`, `ex_pc = 0xFFFF_FFF0`, `ex_imm = 0x20`: `redirect_pc = 0x0000_0010` (wrap).
- Mispredict with `redirect_ready` low for 5 cycles: `redirect_valid` and `redirect_pc` are stable and `ex_ready = 0` throughout. `flush` rises one cycle after ready.
- Six taken branches at `pc = 0x40`: counter saturates at 11. A same-cycle `if_pc = 0x40` lookup during the update returns the pre-update bit.
- `rst_n` low during REDIRECT: `redirect_valid` drops asynchronously, no `flush` follows, BHT returns to 01. `funct3 = 010` is accepted as not-taken with no BHT change.
